beta_top_bank: RTL and testbench
================================

Name: beta_top_bank

Overview:
- Top-stage beta (partial-sum) storage for the list SCAN decoder; generalises the fixed two-path, 16-slice beta top RAM to L paths and ROWS rows per path.
- Holds one beta vector per list path. Supports per-lane masked writes and a permuted read (each output lane picks a source path).
- Has a multi-cycle path-copy engine for list pruning (overwrite a dropped path with a surviving one).
- Sits between the top-stage PE array (writer) and the top-stage f/g units (reader).

Parameters:
- N, 1024, code length.
- P, 64, PE parallelism; beta values per lane word.
- Q, 6, bits per beta value.
- L, 2, list size (number of path lanes); power of two, at least 2.
- ROWS, N/(4*P), rows per path; power of two, at least 2.
- AW, clog2(ROWS), row-address width (localparam).
- LW, clog2(L), path-index width (localparam).

Ports:
- clk  in  1  clock.
- rst  in  1  reset; synchronous, active-high.
- w_en  in  1  write strobe.
- w_addr  in  AW  write row.
- w_mask  in  L  per-lane write enable; lane k written only if w_mask[k].
- b_in  in  L*P*Q  lane k at bits [k*P*Q +: P*Q].
- r_en  in  1  read strobe.
- r_addr  in  AW  read row.
- r_sel  in  L*LW  source path for output lane k at [k*LW +: LW].
- cp_start  in  1  start path copy.
- cp_src  in  LW  copy source path.
- cp_dst  in  LW  copy destination path.
- busy  out  1  copy engine active.
- b_out  out  L*P*Q  registered read data.
- b_valid  out  1  b_out holds data from a read.

Behaviour:
- Storage: L x ROWS words of P*Q bits. Reset clears all storage, b_out, b_valid and busy to 0, and returns the FSM to IDLE.
- Write (w_en=1, busy=0): for each k with w_mask[k], mem[k][w_addr] <= lane k of b_in. Lanes with mask 0 are unchanged.
- Read:
  - Latency 1 cycle. When r_en=1 in cycle t, cycle t+1 gives b_out lane k = mem[r_sel_k][r_addr] and b_valid=1.
  - When r_en=0, b_out <= 0 and b_valid <= 0 (zero-when-idle is required).
  - Read and write in the same cycle to the same row: read returns the NEW data for the lanes being written (write-first bypass, per lane via w_mask). Other lanes return stored data.
  - Duplicate r_sel entries are legal; several output lanes may show the same path.
- Copy FSM, states IDLE, COPY:
  - IDLE: cp_start=1 latches src/dst, sets row counter to 0, goes to COPY, busy=1 from the next cycle.
  - COPY: each cycle mem[dst][cnt] <= mem[src][cnt] and cnt++. After row ROWS-1 the FSM returns to IDLE, so busy is high for exactly ROWS cycles.
  - cp_src==cp_dst: FSM still runs for ROWS cycles; data is unchanged.
  - cp_start while busy=1 is ignored.
- While busy=1:
  - w_en is ignored (the writer must stall on busy).
  - r_en is serviced. Rows not yet copied read old dst contents; copied rows read new contents. A read of the row being copied in that cycle returns the pre-copy value.
- Address wrap: w_addr and r_addr are exactly AW bits, so no out-of-range access exists. The copy counter wraps to 0 at exit.
- rst mid-copy: copy aborts and storage clears. A partially copied state is never visible after reset.
- Simultaneous cp_start and w_en in IDLE: the write in that cycle completes, then the copy begins. The copy reads post-write data from the next cycle.

Decomposition:
- Shared package holds:
  - beta_t, a Q-bit value type;
  - lane word width P*Q;
  - the clog2 helper;
  - the AW/LW derivation, so PE array, controller and bank agree.
- One natural sub-module: beta_lane_ram, a single-path ROWS x P*Q RAM with one write port and two read ports (read bus + copy tap).
- beta_top_bank instantiates L of these plus the r_sel crossbar, bypass muxes and copy FSM.

Test Plan:
1. Reset/idle read:
   - assert rst 2 cycles, then r_en=1, r_addr=0, r_sel={1,0} -> b_out=0, b_valid=1.
   - then r_en=0 -> b_out=0, b_valid=0.
2. Masked write/permuted read (L=2):
   - write row 3, mask 2'b11, lane0=all 6'h15, lane1=all 6'h2A.
   - write row 3, mask 2'b01, lane0=all 6'h01.
   - read row 3 with r_sel={0,1} -> lane0=all 6'h2A, lane1=all 6'h01.
3. Bypass: same cycle w_en row 2 mask 2'b10 lane1=all 6'h3F and r_en row 2 r_sel={1,1} -> next cycle both lanes all 6'h3F.
4. Path copy:
   - fill path0 rows 0..ROWS-1 with row index; cp_start src=0 dst=1 -> busy high exactly ROWS=4 cycles.
   - then read r_sel={1,1} each row -> each row returns its index.
   - w_en during busy leaves memory unchanged.
5. Copy boundary:
   - cp_start during busy is ignored (busy still drops after ROWS cycles).
   - cp_src==cp_dst leaves data unchanged.
   - rst in COPY cycle 2 -> busy=0 next cycle; all rows read 0.
6. Randomised: 10k cycles of random w_en/w_mask/r_en/r_sel/cp_start against a reference model -> b_out and b_valid match every cycle.

Source files
------------

// File: rtl/beta_top_bank_pkg.sv
// Shared types and geometry for the top-stage beta bank.
// The PE array, controller and bank all take their widths from here.
package beta_top_bank_pkg;

  function automatic int clog2(input int v);
    int r;
    for (r = 0; (1 << r) < v; r++) begin
    end
    return r;
  endfunction

  localparam int N      = 1024;
  localparam int P      = 64;
  localparam int Q      = 6;
  localparam int L      = 2;
  localparam int ROWS   = N / (4 * P);
  localparam int AW     = clog2(ROWS);
  localparam int LW     = clog2(L);
  localparam int WORD_W = P * Q;
  localparam int BUS_W  = L * WORD_W;

  typedef logic [Q-1:0]   beta_t;
  typedef beta_t [P-1:0]  word_t;
  typedef logic [AW-1:0]  row_t;
  typedef logic [LW-1:0]  path_t;

  typedef enum logic {ST_IDLE, ST_COPY} cp_state_e;

endpackage

// File: rtl/beta_top_bank_if.sv
// Writer/reader/copy-control bundle of the beta bank.
interface beta_top_bank_if;
  import beta_top_bank_pkg::*;

  logic               w_en;
  row_t               w_addr;
  logic [L-1:0]       w_mask;
  logic [BUS_W-1:0]   b_in;
  logic               r_en;
  row_t               r_addr;
  logic [L*LW-1:0]    r_sel;
  logic               cp_start;
  path_t              cp_src;
  path_t              cp_dst;
  logic               busy;
  logic [BUS_W-1:0]   b_out;
  logic               b_valid;

  modport master (
    output w_en, w_addr, w_mask, b_in, r_en, r_addr, r_sel, cp_start, cp_src, cp_dst,
    input  busy, b_out, b_valid
  );

  modport slave (
    input  w_en, w_addr, w_mask, b_in, r_en, r_addr, r_sel, cp_start, cp_src, cp_dst,
    output busy, b_out, b_valid
  );
endinterface

// File: rtl/beta_lane_ram.sv
// One path of beta storage: ROWS x P*Q, one write port, two read ports.
// A per-row valid flag gives a single-cycle clear without touching the array.
module beta_lane_ram
  import beta_top_bank_pkg::*;
(
  input  logic  clk,
  input  logic  rst,
  input  logic  we_i,
  input  row_t  waddr_i,
  input  word_t wdata_i,
  input  row_t  raddr_a_i,
  output word_t rdata_a_o,
  input  row_t  raddr_b_i,
  output word_t rdata_b_o
);

  word_t           mem_q [ROWS];
  logic [ROWS-1:0] vld_q;

  always_ff @(posedge clk) begin
    if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      vld_q <= '0;
    end else if (we_i) begin
      vld_q[waddr_i] <= 1'b1;
    end
  end

  assign rdata_a_o = vld_q[raddr_a_i] ? mem_q[raddr_a_i] : '0;
  assign rdata_b_o = vld_q[raddr_b_i] ? mem_q[raddr_b_i] : '0;

endmodule

// File: rtl/beta_top_bank.sv
// L-path beta bank: masked writes, permuted registered read with write-first
// bypass, and a row-serial path-copy engine for list pruning.
module beta_top_bank
  import beta_top_bank_pkg::*;
(
  input  logic            clk,
  input  logic            rst,
  beta_top_bank_if.slave  bus
);

  cp_state_e        state_q, state_d;
  row_t             cnt_q, cnt_d;
  path_t            src_q, src_d;
  path_t            dst_q, dst_d;
  logic [BUS_W-1:0] b_out_q, b_out_d;
  logic             b_valid_q;
  logic             busy;

  word_t rd_word [L];
  word_t cp_word [L];
  word_t cp_src_word;

  assign busy        = (state_q == ST_COPY);
  assign cp_src_word = cp_word[src_q];

  // While copying, the copy engine owns every write port and w_en is dropped.
  for (genvar gi = 0; gi < L; gi++) begin : g_lane
    logic  lane_we;
    row_t  lane_addr;
    word_t lane_wdata;

    assign lane_we    = busy ? (dst_q == path_t'(gi)) : (bus.w_en & bus.w_mask[gi]);
    assign lane_addr  = busy ? cnt_q : bus.w_addr;
    assign lane_wdata = busy ? cp_src_word : word_t'(bus.b_in[gi*WORD_W +: WORD_W]);

    beta_lane_ram u_ram (
      .clk       (clk),
      .rst       (rst),
      .we_i      (lane_we),
      .waddr_i   (lane_addr),
      .wdata_i   (lane_wdata),
      .raddr_a_i (bus.r_addr),
      .rdata_a_o (rd_word[gi]),
      .raddr_b_i (cnt_q),
      .rdata_b_o (cp_word[gi])
    );
  end

  // Output crossbar; a same-row host write is forwarded per source path.
  for (genvar gi = 0; gi < L; gi++) begin : g_out
    path_t sel;
    logic  byp;
    word_t rd_lane;

    assign sel     = bus.r_sel[gi*LW +: LW];
    assign byp     = ~busy & bus.w_en & bus.w_mask[sel] & (bus.w_addr == bus.r_addr);
    assign rd_lane = byp ? word_t'(bus.b_in[sel*WORD_W +: WORD_W]) : rd_word[sel];
    assign b_out_d[gi*WORD_W +: WORD_W] = bus.r_en ? rd_lane : '0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      b_out_q   <= '0;
      b_valid_q <= 1'b0;
    end else begin
      b_out_q   <= b_out_d;
      b_valid_q <= bus.r_en;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    src_d   = src_q;
    dst_d   = dst_q;
    case (state_q)
      ST_IDLE: begin
        if (bus.cp_start) begin
          state_d = ST_COPY;
          cnt_d   = '0;
          src_d   = bus.cp_src;
          dst_d   = bus.cp_dst;
        end
      end
      ST_COPY: begin
        cnt_d = cnt_q + row_t'(1);
        if (cnt_q == row_t'(ROWS - 1)) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      src_q   <= '0;
      dst_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      src_q   <= src_d;
      dst_q   <= dst_d;
    end
  end

  assign bus.busy    = busy;
  assign bus.b_out   = b_out_q;
  assign bus.b_valid = b_valid_q;

endmodule

// File: tb/tb_beta_top_bank.sv
// Directed and model-checked stimulus for beta_top_bank (L=2, ROWS=4).
module tb_beta_top_bank;
  import beta_top_bank_pkg::*;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  beta_top_bank_if bus ();

  beta_top_bank dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int errors = 0;
  int checks = 0;

  task automatic check(input string tag, input logic [BUS_W-1:0] got, input logic [BUS_W-1:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic word_t rep(input beta_t v);
    return {P{v}};
  endfunction

  function automatic logic [BUS_W-1:0] lanes(input word_t hi, input word_t lo);
    return {hi, lo};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    bus.w_en     = 1'b0;
    bus.w_addr   = '0;
    bus.w_mask   = '0;
    bus.b_in     = '0;
    bus.r_en     = 1'b0;
    bus.r_addr   = '0;
    bus.r_sel    = '0;
    bus.cp_start = 1'b0;
    bus.cp_src   = '0;
    bus.cp_dst   = '0;
  endtask

  // Counts busy cycles after a copy start; cp_start is held for 'hold' cycles
  // and, if wr is set, a write is attempted on every busy cycle.
  task automatic wait_copy(input int hold, input bit wr, output int n);
    n = 0;
    for (int i = 0; i < 12; i++) begin
      bus.cp_start = (i < hold);
      bus.w_en     = wr & bus.busy;
      if (bus.busy) n++;
      tick();
    end
    bus.cp_start = 1'b0;
    bus.w_en     = 1'b0;
  endtask

  task automatic read_row(input int row, input logic [L*LW-1:0] sel);
    bus.r_en   = 1'b1;
    bus.r_addr = row_t'(row);
    bus.r_sel  = sel;
    tick();
    bus.r_en   = 1'b0;
  endtask

  word_t            m_mem [L][ROWS];
  bit               m_busy;
  int               m_cnt, m_src, m_dst;
  logic [BUS_W-1:0] rb, exp_out;
  int               n;

  initial begin
    rst = 1'b1;
    idle_inputs();
    tick();
    tick();
    check("rst_valid", bus.b_valid, 0);
    check("rst_busy", bus.busy, 0);
    rst = 1'b0;

    // 1. idle read of cleared storage
    read_row(0, 2'b10);
    check("idle_rd_out", bus.b_out, '0);
    check("idle_rd_vld", bus.b_valid, 1);
    tick();
    check("idle_off_out", bus.b_out, '0);
    check("idle_off_vld", bus.b_valid, 0);

    // 2. masked write and permuted read
    bus.w_en = 1'b1; bus.w_addr = 3; bus.w_mask = 2'b11;
    bus.b_in = lanes(rep(6'h2A), rep(6'h15));
    tick();
    bus.w_mask = 2'b01;
    bus.b_in   = lanes(rep(6'h3C), rep(6'h01));
    tick();
    bus.w_en = 1'b0;
    read_row(3, 2'b01);
    check("perm_rd", bus.b_out, lanes(rep(6'h01), rep(6'h2A)));
    read_row(3, 2'b00);
    check("perm_rd_dup", bus.b_out, lanes(rep(6'h01), rep(6'h01)));

    // 3. write-first bypass on the same row
    bus.w_en = 1'b1; bus.w_addr = 2; bus.w_mask = 2'b10;
    bus.b_in = lanes(rep(6'h3F), rep(6'h07));
    read_row(2, 2'b11);
    bus.w_en = 1'b0;
    check("bypass", bus.b_out, lanes(rep(6'h3F), rep(6'h3F)));
    read_row(2, 2'b10);
    check("bypass_mask", bus.b_out, lanes(rep(6'h3F), rep(6'h00)));

    // 4. path copy 0 -> 1 with an ignored write during busy
    for (int i = 0; i < ROWS; i++) begin
      bus.w_en = 1'b1; bus.w_addr = row_t'(i); bus.w_mask = 2'b01;
      bus.b_in = lanes(rep(6'h00), rep(beta_t'(i)));
      tick();
    end
    bus.w_en = 1'b0;
    bus.cp_start = 1'b1; bus.cp_src = 0; bus.cp_dst = 1;
    tick();
    bus.cp_start = 1'b0;
    bus.w_addr = 1; bus.w_mask = 2'b11; bus.b_in = lanes(rep(6'h33), rep(6'h33));
    wait_copy(0, 1'b1, n);
    check("copy_busy_len", 32'(n), 32'(ROWS));
    for (int i = 0; i < ROWS; i++) begin
      read_row(i, 2'b11);
      check($sformatf("copy_row%0d", i), bus.b_out, lanes(rep(beta_t'(i)), rep(beta_t'(i))));
    end
    read_row(1, 2'b00);
    check("copy_src_kept", bus.b_out, lanes(rep(6'h01), rep(6'h01)));

    // 5a. cp_start while busy is ignored
    bus.cp_start = 1'b1; bus.cp_src = 1; bus.cp_dst = 0;
    tick();
    bus.cp_src = 0; bus.cp_dst = 1;
    wait_copy(2, 1'b0, n);
    check("restart_ign", 32'(n), 32'(ROWS));

    // 5b. src == dst leaves data unchanged
    bus.w_en = 1'b1; bus.w_addr = 2; bus.w_mask = 2'b10;
    bus.b_in = lanes(rep(6'h2A), rep(6'h11));
    tick();
    bus.w_en = 1'b0;
    bus.cp_start = 1'b1; bus.cp_src = 1; bus.cp_dst = 1;
    tick();
    bus.cp_start = 1'b0;
    wait_copy(0, 1'b0, n);
    check("self_busy_len", 32'(n), 32'(ROWS));
    read_row(2, 2'b10);
    check("self_copy", bus.b_out, lanes(rep(6'h2A), rep(6'h02)));

    // 5c. reset in the second copy cycle
    bus.cp_start = 1'b1; bus.cp_src = 0; bus.cp_dst = 1;
    tick();
    bus.cp_start = 1'b0;
    tick();
    rst = 1'b1;
    tick();
    check("rst_mid_busy", bus.busy, 0);
    rst = 1'b0;
    for (int i = 0; i < ROWS; i++) begin
      read_row(i, 2'b10);
      check($sformatf("rst_clr_row%0d", i), bus.b_out, '0);
    end

    // 6. randomised traffic against a behavioural model
    for (int p = 0; p < L; p++)
      for (int r = 0; r < ROWS; r++) m_mem[p][r] = '0;
    m_busy = 0; m_cnt = 0; m_src = 0; m_dst = 0;
    for (int c = 0; c < 10000; c++) begin
      for (int j = 0; j < BUS_W / 32; j++) rb[j*32 +: 32] = $urandom;
      bus.b_in     = rb;
      bus.w_en     = 1'($urandom_range(0, 1));
      bus.w_addr   = row_t'($urandom_range(0, ROWS - 1));
      bus.w_mask   = L'($urandom);
      bus.r_en     = 1'($urandom_range(0, 1));
      bus.r_addr   = row_t'($urandom_range(0, ROWS - 1));
      bus.r_sel    = (L*LW)'($urandom);
      bus.cp_start = ($urandom_range(0, 19) == 0);
      bus.cp_src   = path_t'($urandom_range(0, L - 1));
      bus.cp_dst   = path_t'($urandom_range(0, L - 1));

      exp_out = '0;
      if (bus.r_en) begin
        for (int k = 0; k < L; k++) begin
          int s;
          word_t v;
          s = int'(bus.r_sel[k*LW +: LW]);
          v = m_mem[s][bus.r_addr];
          if (!m_busy && bus.w_en && bus.w_mask[s] && bus.w_addr == bus.r_addr)
            v = rb[s*WORD_W +: WORD_W];
          exp_out[k*WORD_W +: WORD_W] = v;
        end
      end

      if (m_busy) begin
        m_mem[m_dst][m_cnt] = m_mem[m_src][m_cnt];
        if (m_cnt == ROWS - 1) begin
          m_busy = 0;
          m_cnt  = 0;
        end else begin
          m_cnt++;
        end
      end else begin
        if (bus.w_en)
          for (int k = 0; k < L; k++)
            if (bus.w_mask[k]) m_mem[k][bus.w_addr] = rb[k*WORD_W +: WORD_W];
        if (bus.cp_start) begin
          m_busy = 1;
          m_cnt  = 0;
          m_src  = int'(bus.cp_src);
          m_dst  = int'(bus.cp_dst);
        end
      end

      tick();
      check("rnd_out", bus.b_out, exp_out);
      check("rnd_vld", bus.b_valid, bus.r_en);
      check("rnd_busy", bus.busy, m_busy);
    end

    idle_inputs();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
